// File: rtl/mem_ctrl_pkg.sv
// Shared constants and state encoding for the x32 single-port memory controller.
package mem_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_RD = 3'd1,
        ST_LOAD_RD  = 3'd2,
        ST_RMW_RD   = 3'd3,
        ST_RMW_WR   = 3'd4,
        ST_ERR_RSP  = 3'd5
    } mem_state_t;

    // Little-endian lane bit offsets within a 32-bit word.
    function automatic logic [4:0] byte_shift(input logic [1:0] offset);
        return {offset, 3'b000};
    endfunction

    function automatic logic [4:0] half_shift(input logic [1:0] offset);
        return {offset[1], 4'b0000};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge
// and access alignment/legality checks.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b     = 8'(rdata >> byte_shift(offset));
        lane_h     = 16'(rdata >> half_shift(offset));
        load_data  = '0;
        merge_data = wdata;
        misaligned = 1'b0;
        illegal    = 1'b0;

        if (is_store) begin
            case (funct3)
                F3_SB: merge_data = (rdata & ~(BYTE_MASK << byte_shift(offset)))
                                  | ((wdata & BYTE_MASK) << byte_shift(offset));
                F3_SH: begin
                    merge_data = (rdata & ~(HALF_MASK << half_shift(offset)))
                               | ((wdata & HALF_MASK) << half_shift(offset));
                    misaligned = offset[0];
                end
                F3_SW:   misaligned = (offset != 2'b00);
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB:  load_data = {{24{lane_b[7]}}, lane_b};
                F3_LBU: load_data = {24'h0, lane_b};
                F3_LH: begin
                    load_data  = {{16{lane_h[15]}}, lane_h};
                    misaligned = offset[0];
                end
                F3_LHU: begin
                    load_data  = {16'h0, lane_h};
                    misaligned = offset[0];
                end
                F3_LW: begin
                    load_data  = rdata;
                    misaligned = (offset != 2'b00);
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous word memory between the fetch port and the load/store
// port: arbitration with fetch anti-starvation, sub-word loads and RMW stores.
module mem_port_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_funct3,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam int          CW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    mem_state_t    state, state_nxt;
    logic [CW-1:0] starve_cnt;

    logic          r_store;
    logic [2:0]    r_funct3;
    logic [1:0]    r_offset;
    logic [31:0]   r_wdata;
    logic [AW-1:0] r_waddr;

    logic          a_store;
    logic [2:0]    a_funct3;
    logic [1:0]    a_offset;
    logic [31:0]   a_wdata;
    logic [31:0]   load_data, merge_data;
    logic          misaligned, illegal, out_of_range, d_bad, fetch_wins, sub_store;

    logic unused_if_addr;
    assign unused_if_addr = ^{if_addr[31:AW+2], if_addr[1:0]};

    // In IDLE the checks look at the live request; afterwards the latched one.
    always_comb begin
        if (state == ST_IDLE) begin
            a_store  = d_we;
            a_funct3 = d_funct3;
            a_offset = d_addr[1:0];
            a_wdata  = d_wdata;
        end else begin
            a_store  = r_store;
            a_funct3 = r_funct3;
            a_offset = r_offset;
            a_wdata  = r_wdata;
        end
    end

    mem_lane_align u_align (
        .is_store   (a_store),
        .funct3     (a_funct3),
        .offset     (a_offset),
        .rdata      (mem_rdata),
        .wdata      (a_wdata),
        .load_data  (load_data),
        .merge_data (merge_data),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    always_comb begin
        out_of_range = ({1'b0, d_addr} >= BYTE_LIMIT);
        d_bad        = misaligned | illegal | out_of_range;
        fetch_wins   = if_req && (!d_req || starve_cnt >= STARVE_MAX);
        sub_store    = d_we && (d_funct3 == F3_SB || d_funct3 == F3_SH);

        state_nxt = state;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        d_err     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Outputs are forced quiet while reset is held so an aborted RMW never writes.
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (fetch_wins) begin
                        if_gnt    = 1'b1;
                        mem_en    = 1'b1;
                        mem_addr  = if_addr[AW+1:2];
                        state_nxt = ST_FETCH_RD;
                    end else if (d_req) begin
                        d_gnt = 1'b1;
                        if (d_bad) begin
                            state_nxt = ST_ERR_RSP;
                        end else begin
                            mem_en   = 1'b1;
                            mem_addr = d_addr[AW+1:2];
                            if (sub_store) begin
                                state_nxt = ST_RMW_RD;
                            end else begin
                                mem_we    = d_we;
                                mem_wdata = d_we ? d_wdata : '0;
                                state_nxt = ST_LOAD_RD;
                            end
                        end
                    end
                end
                ST_FETCH_RD: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                    state_nxt = ST_IDLE;
                end
                ST_LOAD_RD: begin
                    d_rvalid  = 1'b1;
                    d_rdata   = r_store ? '0 : load_data;
                    state_nxt = ST_IDLE;
                end
                ST_RMW_RD: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = r_waddr;
                    mem_wdata = merge_data;
                    state_nxt = ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    d_rvalid  = 1'b1;
                    state_nxt = ST_IDLE;
                end
                ST_ERR_RSP: begin
                    d_rvalid  = 1'b1;
                    d_err     = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            r_store    <= 1'b0;
            r_funct3   <= '0;
            r_offset   <= '0;
            r_wdata    <= '0;
            r_waddr    <= '0;
        end else begin
            state <= state_nxt;
            if (if_gnt)
                starve_cnt <= '0;
            else if (if_req && starve_cnt < STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
            if (d_gnt) begin
                r_store  <= d_we;
                r_funct3 <= d_funct3;
                r_offset <= d_addr[1:0];
                r_wdata  <= d_wdata;
                r_waddr  <= d_addr[AW+1:2];
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-level reference memory, per-cycle arbitration
// model and randomized loads/stores against a behavioural memory array.
module tb_mem_port_arbiter;
    localparam int DEPTH  = 1024;
    localparam int AW     = 10;
    localparam int LIMIT  = 4;
    localparam int NBYTES = DEPTH * 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_gnt, if_rvalid;
    logic [31:0]   if_addr, if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [2:0]    d_funct3;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.DEPTH_WORDS(DEPTH), .STARVE_LIMIT(LIMIT), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory array seen by the DUT.
    logic [31:0] seed_mem [DEPTH];
    logic [31:0] pmem [DEPTH];
    logic        init_go = 1'b0;
    always @(posedge clk) begin
        if (init_go) begin
            for (int i = 0; i < DEPTH; i++) pmem[i] <= seed_mem[i];
        end else if (mem_en) begin
            if (mem_we) pmem[mem_addr] <= mem_wdata;
            else        mem_rdata <= pmem[mem_addr];
        end
    end

    // Reference model: byte-addressed memory.
    logic [7:0] rb [NBYTES];

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a & 32'(NBYTES - 1)) & ~3;
        return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int b;
        b = int'(a);
        case (f3)
            3'b000:  return {{24{rb[b][7]}}, rb[b]};
            3'b001:  return {{16{rb[b+1][7]}}, rb[b+1], rb[b]};
            3'b010:  return ref_word(a);
            3'b100:  return {24'h0, rb[b]};
            3'b101:  return {16'h0, rb[b+1], rb[b]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int b;
        b = int'(a);
        case (f3)
            3'b000: rb[b] = wd[7:0];
            3'b001: begin rb[b] = wd[7:0]; rb[b+1] = wd[15:8]; end
            default: for (int i = 0; i < 4; i++) rb[b+i] = wd[8*i +: 8];
        endcase
    endtask

    // Results of the last run_data transaction; cycle 0 is the grant cycle.
    int            op_gnt_lat, op_rv_lat, op_we_cyc, op_en_cnt, op_we_cnt;
    logic [31:0]   op_rdata, op_we_data;
    logic [AW-1:0] op_we_addr;
    logic          op_err;

    task automatic run_data(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        op_gnt_lat = -1; op_rv_lat = -1; op_we_cyc = -1; op_en_cnt = 0; op_we_cnt = 0;
        op_rdata = 32'hx; op_we_data = 32'hx; op_we_addr = 'x; op_err = 1'bx;
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (d_gnt) begin op_gnt_lat = k; break; end
            @(negedge clk);
        end
        if (op_gnt_lat < 0) begin d_req = 1'b0; return; end
        for (int k = 0; k < 8; k++) begin
            if (mem_en) op_en_cnt++;
            if (mem_we) begin
                op_we_cnt++;
                if (op_we_cyc < 0) begin op_we_cyc = k; op_we_data = mem_wdata; op_we_addr = mem_addr; end
            end
            if (d_rvalid) begin op_rv_lat = k; op_rdata = d_rdata; op_err = d_err; break; end
            @(negedge clk);
            if (k == 0) d_req = 1'b0;
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [112:0] outs;
        @(negedge clk);
        reset = 1'b1; if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h44;
        #1;
        outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err, mem_en, mem_we, mem_addr, mem_wdata};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", outs); end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; reset = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b101};
        logic [31:0] ads [3] = '{32'h14, 32'h14, 32'h16};
        logic [31:0] exp [3] = '{32'hFFFFFFE0, 32'h000000E0, 32'h0000FFFF};
        logic [2:0]  legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            run_data(1'b0, f3s[i], ads[i], 32'h0);
            checks++;
            if (op_rdata !== exp[i] || op_err !== 1'b0) begin
                failures++; $display("FAIL load_vec%0d: got %h err %b want %h err 0", i, op_rdata, op_err, exp[i]);
            end
            checks++;
            if (op_gnt_lat !== 0 || op_rv_lat !== 1) begin
                failures++; $display("FAIL load_vec%0d_lat: got gnt %0d rv %0d want 0 1", i, op_gnt_lat, op_rv_lat);
            end
        end
        for (int i = 0; i < 12; i++) begin
            f3 = legal[$urandom_range(4, 0)];
            a  = $urandom_range(NBYTES - 1, 0) & ~((1 << f3[1:0]) - 1);
            run_data(1'b0, f3, a, $urandom);
            checks++;
            if (op_rdata !== ref_load(f3, a) || op_err !== 1'b0 || op_rv_lat !== 1 || op_we_cnt !== 0) begin
                failures++;
                $display("FAIL load_rand f3=%0d a=%h: got %h err %b rv %0d we %0d want %h err 0 rv 1 we 0",
                         f3, a, op_rdata, op_err, op_rv_lat, op_we_cnt, ref_load(f3, a));
            end
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3;
        logic [31:0] a, wd;
        run_data(1'b1, 3'b000, 32'h0D, 32'h000000AA);
        ref_store(3'b000, 32'h0D, 32'hAA);
        checks++;
        if (op_we_cyc !== 1 || op_we_cnt !== 1 || op_we_addr !== AW'(3)) begin
            failures++; $display("FAIL sb_write_timing: got cyc %0d cnt %0d addr %0d want 1 1 3", op_we_cyc, op_we_cnt, op_we_addr);
        end
        checks++;
        if (op_we_data !== 32'h1122AA44) begin
            failures++; $display("FAIL sb_merge: got %h want 1122aa44", op_we_data);
        end
        checks++;
        if (op_rv_lat !== 2 || op_rdata !== 32'h0 || op_err !== 1'b0) begin
            failures++; $display("FAIL sb_rsp: got rv %0d rdata %h err %b want 2 0 0", op_rv_lat, op_rdata, op_err);
        end
        for (int i = 0; i < 10; i++) begin
            f3 = 3'($urandom_range(2, 0));
            a  = $urandom_range(NBYTES - 1, 0) & ~((1 << f3[1:0]) - 1);
            wd = $urandom;
            run_data(1'b1, f3, a, wd);
            ref_store(f3, a, wd);
            checks++;
            if (op_rv_lat !== ((f3 == 3'b010) ? 1 : 2) || op_we_cyc !== ((f3 == 3'b010) ? 0 : 1) ||
                op_rdata !== 32'h0 || op_err !== 1'b0) begin
                failures++;
                $display("FAIL store_rand f3=%0d a=%h: got rv %0d wecyc %0d rdata %h err %b", f3, a, op_rv_lat, op_we_cyc, op_rdata, op_err);
            end
            run_data(1'b0, 3'b010, a & ~32'h3, 32'h0);
            checks++;
            if (op_rdata !== ref_word(a)) begin
                failures++; $display("FAIL store_readback a=%h: got %h want %h", a, op_rdata, ref_word(a));
            end
        end
    endtask

    task automatic test_errors();
        logic        wes [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] ads [5] = '{32'h0102, 32'h0001, 32'(NBYTES), 32'h40, 32'h40};
        for (int i = 0; i < 5; i++) begin
            run_data(wes[i], f3s[i], ads[i], 32'hFFFF_FFFF);
            checks++;
            if (op_gnt_lat !== 0 || op_rv_lat !== 1 || op_err !== 1'b1 || op_rdata !== 32'h0 || op_en_cnt !== 0) begin
                failures++;
                $display("FAIL err_case%0d: got gnt %0d rv %0d err %b rdata %h en %0d want 0 1 1 0 0",
                         i, op_gnt_lat, op_rv_lat, op_err, op_rdata, op_en_cnt);
            end
        end
    endtask

    task automatic test_starve();
        int cnt_m;
        bit busy, ef, ed;
        int nfetch;
        do_reset();
        cnt_m = 0; busy = 0; nfetch = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h80;
        for (int k = 0; k < 30; k++) begin
            #1;
            ef = !busy && (cnt_m >= LIMIT);
            ed = !busy && !ef;
            checks++;
            if (if_gnt !== ef || d_gnt !== ed) begin
                failures++; $display("FAIL starve_cyc%0d: got if_gnt %b d_gnt %b want %b %b", k, if_gnt, d_gnt, ef, ed);
            end
            if (ef) nfetch++;
            cnt_m = ef ? 0 : ((cnt_m < LIMIT) ? cnt_m + 1 : cnt_m);
            busy  = ef || ed;
            @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0;
        checks++;
        if (nfetch < 3) begin failures++; $display("FAIL starve_fetch_count: got %0d want >=3", nfetch); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random_arb();
        bit          if_pend, d_pend, busy, pf, pd, ef, ed;
        int          cnt_m;
        logic [31:0] pf_addr, pd_addr;
        logic [2:0]  pd_f3;
        logic [2:0]  legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        do_reset();
        if_pend = 0; d_pend = 0; busy = 0; pf = 0; pd = 0; cnt_m = 0;
        pf_addr = '0; pd_addr = '0; pd_f3 = '0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (pf) if_pend = 0;
            if (pd) d_pend = 0;
            if (!if_pend && $urandom_range(1, 0) == 1) begin if_pend = 1; if_addr = $urandom & ~32'h3; end
            if (!d_pend && $urandom_range(1, 0) == 1) begin
                d_pend = 1; d_we = 1'b0; d_funct3 = legal[$urandom_range(4, 0)];
                d_addr = $urandom_range(NBYTES - 1, 0) & ~((1 << d_funct3[1:0]) - 1);
            end
            if_req = if_pend; d_req = d_pend;
            #1;
            ef = !busy && if_pend && (!d_pend || cnt_m >= LIMIT);
            ed = !busy && d_pend && !ef;
            checks++;
            if (if_gnt !== ef || d_gnt !== ed || if_rvalid !== pf || d_rvalid !== pd) begin
                failures++;
                $display("FAIL arb_cyc%0d: got gnt %b%b rv %b%b want %b%b %b%b", k, if_gnt, d_gnt, if_rvalid, d_rvalid, ef, ed, pf, pd);
            end
            if (pf) begin
                checks++;
                if (if_rdata !== ref_word(pf_addr)) begin
                    failures++; $display("FAIL arb_fetch a=%h: got %h want %h", pf_addr, if_rdata, ref_word(pf_addr));
                end
            end
            if (pd) begin
                checks++;
                if (d_rdata !== ref_load(pd_f3, pd_addr) || d_err !== 1'b0) begin
                    failures++; $display("FAIL arb_load a=%h: got %h err %b want %h", pd_addr, d_rdata, d_err, ref_load(pd_f3, pd_addr));
                end
            end
            if (ef) cnt_m = 0;
            else if (if_pend && cnt_m < LIMIT) cnt_m++;
            busy = ef || ed; pf = ef; pd = ed;
            if (ef) pf_addr = if_addr;
            if (ed) begin pd_addr = d_addr; pd_f3 = d_funct3; end
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== AW'(8)) begin
            failures++; $display("FAIL b2b_sw_grant: got gnt %b we %b wdata %h addr %0d", d_gnt, mem_we, mem_wdata, mem_addr);
        end
        ref_store(3'b010, 32'h20, 32'hDEADBEEF);
        @(negedge clk);
        d_we = 1'b0;
        #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
            failures++; $display("FAIL b2b_sw_rsp: got rv %b rdata %h gnt %b en %b want 1 0 0 0", d_rvalid, d_rdata, d_gnt, mem_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin failures++; $display("FAIL b2b_lw_grant: got %b want 1", d_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL b2b_lw_data: got rv %b rdata %h want 1 deadbeef", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_reset_rmw();
        logic [112:0] outs;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b000; d_addr = 32'h1D; d_wdata = 32'h55;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin failures++; $display("FAIL rst_rmw_grant: got %b want 1", d_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err, mem_en, mem_we, mem_addr, mem_wdata};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL rst_rmw_outputs: got %h want 0", outs); end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (pmem[7] !== ref_word(32'h1C)) begin
            failures++; $display("FAIL rst_rmw_no_write: got %h want %h", pmem[7], ref_word(32'h1C));
        end
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0;
        #1;
        checks++;
        if (if_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== AW'(0)) begin
            failures++; $display("FAIL post_rst_fetch_grant: got gnt %b en %b addr %0d want 1 1 0", if_gnt, mem_en, mem_addr);
        end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== ref_word(32'h0)) begin
            failures++; $display("FAIL post_rst_fetch_data: got rv %b data %h want 1 %h", if_rvalid, if_rdata, ref_word(32'h0));
        end
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < DEPTH; i++) seed_mem[i] = $urandom;
        seed_mem[3] = 32'h11223344;
        seed_mem[5] = 32'hFFFFFFE0;
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < 4; j++) rb[4*i+j] = seed_mem[i][8*j +: 8];
        @(negedge clk);
        init_go = 1'b1;
        @(negedge clk);
        init_go = 1'b0;

        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_back_to_back();
        test_starve();
        test_random_arb();
        test_reset_rmw();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
